multibyte_add_seq: RTL
======================

// Module: multibyte_add_seq
// PURPOSE
//   Sequential multi-byte adder controller wrapped around the 8-bit ripple adder (para_adder).
//   Latches two NBYTES-wide operands on a start pulse and feeds one byte per cycle, LSB byte
//   first, to the external para_adder. Captures each Sum byte and chains Cout into the next
//   byte's Cin. Signals done with the full-width result, carry-out and signed overflow.
// PARAMETERS
//   NBYTES  4  number of 8-bit slices per operation (>=1); operand width W = 8*NBYTES
// PORTS
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    request; sampled only in IDLE
//   op_a       in   W    operand A, latched when start is accepted
//   op_b       in   W    operand B, latched when start is accepted
//   cin_in     in   1    carry into byte 0, latched when start is accepted
//   busy       out  1    1 whenever state != IDLE
//   done       out  1    one-cycle pulse; result/cout_out/overflow valid from this cycle on
//   result     out  W    sum; held until the next accepted start
//   cout_out   out  1    carry out of the MSB byte; held like result
//   overflow   out  1    two's-complement overflow of the W-bit add; held like result
//   add_a      out  8    byte to para_adder input a
//   add_b      out  8    byte to para_adder input b
//   add_cin    out  1    para_adder Cin
//   add_sum    in   8    para_adder Sum (combinational return)
//   add_cout   in   1    para_adder Cout (combinational return)
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, idx=0, carry=0. All outputs 0: busy, done, result,
//     cout_out, overflow, add_a, add_b, add_cin. Reset mid-RUN aborts the operation; no done.
//   - FSM states are IDLE, RUN and DONE.
//     IDLE: if start=1 at an edge, latch op_a/op_b into a_reg/b_reg, carry<=cin_in, idx<=0,
//       result<=0, go to RUN.
//     RUN: add_a=a_reg[8*idx+:8], add_b=b_reg[8*idx+:8], add_cin=carry (combinational from regs).
//       At each edge: result[8*idx+:8]<=add_sum, carry<=add_cout, idx<=idx+1.
//       At the edge where idx==NBYTES-1, also cout_out<=add_cout and
//       overflow<=(a_reg[W-1]==b_reg[W-1]) && (add_sum[7]!=a_reg[W-1]); go to DONE.
//     DONE: done=1 for exactly this cycle, then unconditionally go to IDLE.
//   - add_a/add_b/add_cin are 0 outside RUN.
//   - Latency: start sampled at edge 0 -> RUN for edges 1..NBYTES -> done high in the cycle
//     after edge NBYTES. The next start can be accepted at edge NBYTES+2 at the earliest.
//   - start while busy (RUN or DONE) is ignored and not queued; op_a/op_b changes while busy
//     have no effect.
//   - idx width is clog2(NBYTES) with a minimum of 1. NBYTES=1 gives one RUN cycle.
//   - Carry chain: cin_in feeds byte 0 only; each byte's Cout feeds the next byte's Cin.
//     Sum wraps modulo 2^W, and the lost carry appears on cout_out.
// TESTING (NBYTES=4, a real para_adder instance wired to the add_* ports)
//   1. 0x00000001+0x00000001, cin 0 -> result 0x00000002, cout 0, ovf 0; done 5 edges after start.
//   2. 0xFFFFFFFF+0x00000001, cin 0 -> result 0x00000000, cout 1, ovf 0 (full carry ripple).
//   3. 0x7FFFFFFF+0x00000001, cin 0 -> result 0x80000000, cout 0, ovf 1.
//   4. 0xFFFFFFFF+0xFFFFFFFF, cin 1 -> result 0xFFFFFFFF, cout 1, ovf 0.
//   5. start again in the 2nd RUN cycle with new operands -> ignored; exactly one done pulse;
//      result equals the first operation's sum.
//   6. rst_n low during RUN -> all outputs 0 immediately and no done pulse; after release,
//      start 0x00000100+0x00000100 -> result 0x00000200.

Source files
------------

// File: rtl/multibyte_add_seq.sv
// Sequential multi-byte adder controller: walks NBYTES byte slices, LSB first, through an
// external 8-bit ripple adder and chains the carry from one slice into the next.
module multibyte_add_seq #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES,
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout_out,
    output logic         overflow,
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    output logic         add_cin,
    input  logic [7:0]   add_sum,
    input  logic         add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t         r_state;
    logic [IW-1:0]  r_idx;
    logic           r_carry;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_result;
    logic           r_cout;
    logic           r_ovf;

    logic           w_run;
    logic [IW+2:0]  w_bit;

    assign w_run = (r_state == RUN);
    assign w_bit = {r_idx, 3'b000};

    // Slice feed is combinational from the latched operands so the adder result
    // is ready to capture at the same edge that advances idx.
    assign add_a    = w_run ? r_a[w_bit +: 8] : 8'h00;
    assign add_b    = w_run ? r_b[w_bit +: 8] : 8'h00;
    assign add_cin  = w_run ? r_carry : 1'b0;

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign result   = r_result;
    assign cout_out = r_cout;
    assign overflow = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= op_a;
                        r_b      <= op_b;
                        r_carry  <= cin_in;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_result[w_bit +: 8] <= add_sum;
                    r_carry              <= add_cout;
                    r_idx                <= r_idx + IW'(1);
                    if (r_idx == LAST) begin
                        // Signed overflow: operands agree in sign but the top sum bit differs.
                        r_cout  <= add_cout;
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (add_sum[7] != r_a[W-1]);
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
